fetch_sequencer: RTL
====================

// Module: fetch_sequencer
// PURPOSE
//   Sequences fetch_unit and the instruction memory port: issues imem requests at the
//   current PC, captures the returned word, and advances the PC (PCEn/pc_up) once per
//   fetched instruction. Presents the instruction to decode with a valid/ready handshake.
//   Handles branch/jump redirects, in-flight flush, bus errors and an ack timeout.
// PARAMETERS
//   XLEN         32  datapath/address width
//   ACK_TIMEOUT  16  max cycles REQ/DRAIN waits for imem_ack before fault; 0 = disabled
// PORTS
//   clk             in   1     clock, rising edge
//   reset           in   1     asynchronous, active-low reset
//   pc              in   XLEN  current PC from fetch_unit (pc_reg)
//   PCEn            out  1     PC load enable to fetch_unit (PCEn_reg)
//   pc_up           out  XLEN  next PC value to fetch_unit (pc_up_reg)
//   imem_req        out  1     instruction memory request
//   imem_addr       out  XLEN  request address
//   imem_ack        in   1     request complete; imem_rdata/imem_err valid this cycle
//   imem_rdata      in   XLEN  fetched instruction word
//   imem_err        in   1     bus error, qualified by imem_ack
//   instr_valid     out  1     instr/instr_pc valid to decode
//   instr           out  XLEN  fetched instruction
//   instr_pc        out  XLEN  PC of instr
//   instr_ready     in   1     decode accepts instr this cycle
//   redirect_valid  in   1     branch/jump taken; overrides sequential PC
//   redirect_pc     in   XLEN  redirect target
//   fetch_fault     out  1     sticky fault flag (bus error or timeout)
// BEHAVIOUR
//   Reset (reset=0): state=IDLE; instr_valid=0, instr=0, instr_pc=0, fetch_fault=0,
//     addr_q=0, timeout cnt=0. imem_req=0, PCEn=0, pc_up=0 are combinational and 0 in IDLE.
//   States: IDLE, REQ, HOLD, DRAIN, FAULT. PCEn/pc_up/imem_req/imem_addr combinational.
//   IDLE : 1 cycle after reset release -> REQ.
//   REQ  : imem_req=1, imem_addr=pc; addr_q<=pc each cycle. Req/addr held until ack.
//     ack&!err&!redirect: instr<=rdata, instr_pc<=pc, instr_valid<=1; PCEn=1,
//       pc_up=pc+4 (mod 2^XLEN, wraps FFFFFFFC->0); -> HOLD.
//     ack&err&!redirect: fetch_fault<=1, PCEn=0; -> FAULT.
//     redirect (any ack): data/err discarded; PCEn=1, pc_up=redirect_pc; -> REQ.
//     redirect&!ack: PCEn=1, pc_up=redirect_pc; -> DRAIN (request still outstanding).
//     no ack, no redirect: stay; cnt++. cnt==ACK_TIMEOUT-1 (if ACK_TIMEOUT!=0) ->
//       fetch_fault<=1, -> FAULT. cnt clears on every state change.
//   HOLD : instr_valid=1, outputs stable. instr_ready -> instr_valid<=0, -> REQ.
//     redirect (wins over instr_ready): instr_valid<=0 (flush), PCEn=1,
//       pc_up=redirect_pc, -> REQ.
//   DRAIN: imem_req=1, imem_addr=addr_q (original address held); on ack data/err
//     discarded, -> REQ. Further redirect in DRAIN: PCEn=1, pc_up=redirect_pc, stay.
//     Timeout rule as REQ.
//   FAULT: imem_req=0, PCEn=0, instr_valid=0. redirect -> fetch_fault<=0, PCEn=1,
//     pc_up=redirect_pc, -> REQ. Otherwise stay.
//   PCEn asserted at most one cycle per transition; fetch_unit loads pc next edge, so the
//     following REQ cycle presents the new pc. Never more than one request outstanding.
//   Async reset mid-request drops imem_req immediately; memory must tolerate abandon.
// TESTING
//   T1 reset, pc=0, ack 1 cycle after req, rdata=00500093, ready=1 -> req addr 0, PCEn pulse
//      pc_up=4, instr_valid with instr=00500093 instr_pc=0; next req at addr 4.
//   T2 instr_ready=0 for 5 cycles in HOLD -> instr/instr_pc stable, no req, no PCEn.
//   T3 redirect_pc=00000100 while REQ waiting (no ack) -> PCEn pulse pc_up=100, DRAIN keeps
//      addr 4 until ack, data dropped, next req at addr 100, no instr_valid for addr 4.
//   T4 ack with imem_err=1 at pc=8 -> fetch_fault=1, req stops; redirect_pc=200 ->
//      fault clears, req at 200.
//   T5 ack withheld 16 cycles (ACK_TIMEOUT=16) -> fetch_fault=1 on 16th cycle; pc=FFFFFFFC
//      fetch -> pc_up=00000000.
//   T6 reset asserted during REQ and HOLD -> all outputs 0 asynchronously, IDLE then REQ.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: one outstanding imem request at the fetch_unit PC, word handed to decode via valid/ready.
// Request-to-valid is one cycle after ack; decode stall holds the word and stops fetching; redirects flush.
module fetch_sequencer #(
  parameter int XLEN        = 32,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc,
  output logic            PCEn,
  output logic [XLEN-1:0] pc_up,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            imem_err,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            fetch_fault
);

  localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  typedef enum logic [2:0] {IDLE, REQ, HOLD, DRAIN, FAULT} state_t;

  state_t          state, state_d;
  logic [XLEN-1:0] addr_q;
  logic [CW-1:0]   cnt, cnt_d;
  logic            instr_valid_d, fetch_fault_d, timeout;
  logic [XLEN-1:0] instr_d, instr_pc_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      fetch_fault <= 1'b0;
      addr_q      <= '0;
      cnt         <= '0;
    end else begin
      state       <= state_d;
      instr_valid <= instr_valid_d;
      instr       <= instr_d;
      instr_pc    <= instr_pc_d;
      fetch_fault <= fetch_fault_d;
      cnt         <= cnt_d;
      if (state == REQ) addr_q <= pc;
    end
  end

  always_comb begin
    state_d       = state;
    cnt_d         = '0;
    instr_valid_d = instr_valid;
    instr_d       = instr;
    instr_pc_d    = instr_pc;
    fetch_fault_d = fetch_fault;
    PCEn          = 1'b0;
    pc_up         = '0;
    imem_req      = 1'b0;
    imem_addr     = '0;
    timeout       = (ACK_TIMEOUT != 0) && (cnt == CW'(ACK_TIMEOUT - 1));

    case (state)
      IDLE: state_d = REQ;

      REQ: begin
        imem_req  = 1'b1;
        imem_addr = pc;
        if (redirect_valid) begin
          // Without an ack the old request is still on the bus and must drain first.
          PCEn    = 1'b1;
          pc_up   = redirect_pc;
          state_d = imem_ack ? REQ : DRAIN;
        end else if (imem_ack) begin
          if (imem_err) begin
            fetch_fault_d = 1'b1;
            state_d       = FAULT;
          end else begin
            instr_valid_d = 1'b1;
            instr_d       = imem_rdata;
            instr_pc_d    = pc;
            PCEn          = 1'b1;
            pc_up         = pc + XLEN'(4);
            state_d       = HOLD;
          end
        end else if (timeout) begin
          fetch_fault_d = 1'b1;
          state_d       = FAULT;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end

      HOLD: begin
        if (redirect_valid) begin
          instr_valid_d = 1'b0;
          PCEn          = 1'b1;
          pc_up         = redirect_pc;
          state_d       = REQ;
        end else if (instr_ready) begin
          instr_valid_d = 1'b0;
          state_d       = REQ;
        end
      end

      DRAIN: begin
        imem_req  = 1'b1;
        imem_addr = addr_q;
        if (redirect_valid) begin
          PCEn  = 1'b1;
          pc_up = redirect_pc;
        end
        if (imem_ack) begin
          state_d = REQ;
        end else if (redirect_valid) begin
          cnt_d = cnt;
        end else if (timeout) begin
          fetch_fault_d = 1'b1;
          state_d       = FAULT;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end

      FAULT: begin
        if (redirect_valid) begin
          fetch_fault_d = 1'b0;
          PCEn          = 1'b1;
          pc_up         = redirect_pc;
          state_d       = REQ;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule
